// File: rtl/sram_readout_ctrl.sv
// Sample SRAM readback sequencer: steps the read port down one word at a time and
// serializes each word's kept byte lanes onto a valid/ready byte stream.
module sram_readout_ctrl #(
    parameter int unsigned MDW    = 32,
    parameter int unsigned CW     = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [CW-1:0]  read_count,
    output logic           busy,
    output logic           done,
    output logic           rd_ready,
    input  logic           rd_valid,
    input  logic [3:0]     rd_keep,
    input  logic [MDW-1:0] rd_data,
    output logic           tx_valid,
    output logic [7:0]     tx_data,
    input  logic           tx_ready
);

    localparam int unsigned LW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [LW-1:0] LatInit = LW'(RD_LAT - 1);

    typedef enum logic [2:0] {StIdle, StWait, StCapt, StSend, StStep, StDone} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [LW-1:0]  lat_q, lat_d;
    logic [MDW-1:0] hold_q, hold_d;
    logic [3:0]     pend_q, pend_d;
    logic [1:0]     lane;
    logic [3:0]     pend_left;

    // Lowest pending lane goes first.
    always_comb begin
        lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) lane = 2'(i);
        end
        pend_left = pend_q & ~(4'b0001 << lane);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            pend_d  = 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        if (read_count != '0) begin
                            cnt_d   = read_count;
                            lat_d   = LatInit;
                            state_d = StWait;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StWait: begin
                    if (lat_q == '0) state_d = StCapt;
                    else             lat_d   = lat_q - LW'(1);
                end
                StCapt: begin
                    hold_d = rd_data;
                    pend_d = rd_keep & {4{rd_valid}};
                    cnt_d  = cnt_q - CW'(1);
                    if (pend_d != 4'd0)    state_d = StSend;
                    else if (cnt_d != '0)  state_d = StStep;
                    else                   state_d = StDone;
                end
                StSend: begin
                    if (tx_ready) begin
                        pend_d = pend_left;
                        if (pend_left == 4'd0) state_d = (cnt_q != '0) ? StStep : StDone;
                    end
                end
                StStep: begin
                    lat_d   = LatInit;
                    state_d = StWait;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lat_q   <= '0;
            hold_q  <= '0;
            pend_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
        end
    end

    assign busy     = (state_q == StWait) || (state_q == StCapt) ||
                      (state_q == StSend) || (state_q == StStep);
    assign done     = (state_q == StDone);
    assign rd_ready = (state_q == StStep);
    assign tx_valid = (state_q == StSend);
    assign tx_data  = tx_valid ? hold_q[{lane, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_sram_readout_ctrl.sv
// Scenario bench for sram_readout_ctrl: a small SRAM model feeds words, expected bytes
// are queued as words are loaded and popped on every byte handshake.
module tb_sram_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] read_count = 16'd0;
    logic        busy, done, rd_ready, tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        rd_valid;
    logic [3:0]  rd_keep;
    logic [31:0] rd_data;

    logic [31:0] mem_data [8];
    logic [3:0]  mem_keep [8];
    logic        mem_vld  [8];
    int          idx = 0;

    logic [7:0]  exp_q [$];
    int          vectors = 0;
    int          misc = 0;
    int          popped = 0;
    int          rdr_cnt = 0;
    int          done_cnt = 0;
    logic        busy_seen = 1'b0;
    logic        txv_seen = 1'b0;
    logic        stall_prev = 1'b0;
    logic        abort_prev = 1'b0;
    logic        rdr_prev = 1'b0;
    logic [7:0]  data_prev = 8'd0;
    logic        ready_toggle = 1'b0;
    logic [3:0]  ready_pat = 4'b1001;
    int          cyc = 0;

    sram_readout_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .read_count (read_count),
        .busy       (busy),
        .done       (done),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_keep    (rd_keep),
        .rd_data    (rd_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    assign rd_data  = mem_data[idx];
    assign rd_keep  = mem_keep[idx];
    assign rd_valid = mem_vld[idx];

    always @(posedge clk) begin
        if (rd_ready) idx <= idx + 1;
    end

    // Scoreboard and protocol monitor; samples half a cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
            rdr_prev   = 1'b0;
        end else begin
            if (tx_valid) txv_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (done) done_cnt++;
            if (stall_prev && !abort_prev) begin
                vectors++;
                if (tx_valid !== 1'b1 || tx_data !== data_prev) begin
                    misc++;
                    $display("FAIL stall_hold: tx_valid=%0b tx_data=%02h, required 1/%02h",
                             tx_valid, tx_data, data_prev);
                end
            end
            if (rd_ready) begin
                rdr_cnt++;
                vectors++;
                if (rdr_prev) begin
                    misc++;
                    $display("FAIL rd_ready_consec: rd_ready high two cycles, required single");
                end
            end
            if (tx_valid && tx_ready) begin
                logic [7:0] e;
                popped++;
                vectors++;
                if (exp_q.size() == 0) begin
                    misc++;
                    $display("FAIL unexpected_byte: got %02h, required none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        misc++;
                        $display("FAIL byte: got %02h, required %02h", tx_data, e);
                    end
                end
            end
            stall_prev = tx_valid && !tx_ready;
            data_prev  = tx_data;
            abort_prev = abort;
            rdr_prev   = rd_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ready_toggle) tx_ready = ready_pat[cyc % 4];
    endtask

    task automatic clr();
        popped    = 0;
        rdr_cnt   = 0;
        done_cnt  = 0;
        busy_seen = 1'b0;
        txv_seen  = 1'b0;
        exp_q.delete();
        idx = 0;
    endtask

    task automatic push_word(input int i, input logic [31:0] d, input logic [3:0] k,
                             input logic v);
        mem_data[i] = d;
        mem_keep[i] = k;
        mem_vld[i]  = v;
        if (v) begin
            for (int l = 0; l < 4; l++) begin
                if (k[l]) exp_q.push_back(d[8*l +: 8]);
            end
        end
    endtask

    task automatic start_run(input logic [15:0] n);
        read_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int c = 0;
        while (done_cnt == 0 && c < budget) begin
            tick();
            c++;
        end
        vectors++;
        if (done_cnt == 0) begin
            misc++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            misc++;
            $display("FAIL %s_leftover: %0d bytes unsent, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        vectors++;
        if ({busy, done, rd_ready, tx_valid, tx_data} !== 12'h000) begin
            misc++;
            $display("FAIL reset_outputs: got %03h, required 000",
                     {busy, done, rd_ready, tx_valid, tx_data});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full_words();
        clr();
        push_word(0, 32'h44332211, 4'hF, 1'b1);
        push_word(1, 32'h88776655, 4'hF, 1'b1);
        push_word(2, 32'hCCBBAA99, 4'hF, 1'b1);
        start_run(16'd3);
        vectors++;
        if (busy !== 1'b1) begin
            misc++;
            $display("FAIL busy_cycle1: got %0b, required 1", busy);
        end
        tick();
        tick();
        vectors++;
        if (tx_valid !== 1'b0) begin
            misc++;
            $display("FAIL tx_valid_cycle3: got %0b, required 0", tx_valid);
        end
        tick();
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
            misc++;
            $display("FAIL first_byte_cycle4: got %0b/%02h, required 1/11", tx_valid, tx_data);
        end
        wait_done(80, "full");
        vectors++;
        if (rdr_cnt != 2 || done_cnt != 1 || popped != 12) begin
            misc++;
            $display("FAIL full_counts: rd_ready=%0d done=%0d bytes=%0d, required 2/1/12",
                     rdr_cnt, done_cnt, popped);
        end
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            misc++;
            $display("FAIL done_pulse_width: done=%0b busy=%0b, required 0/0", done, busy);
        end
    endtask

    task automatic test_8bit();
        clr();
        push_word(0, 32'hA3A2A1A0, 4'b0001, 1'b1);
        push_word(1, 32'hB3B2B1B0, 4'b1000, 1'b1);
        push_word(2, 32'hC3C2C1C0, 4'b0100, 1'b1);
        start_run(16'd3);
        wait_done(60, "8bit");
        vectors++;
        if (popped != 3 || rdr_cnt != 2) begin
            misc++;
            $display("FAIL 8bit_counts: bytes=%0d rd_ready=%0d, required 3/2", popped, rdr_cnt);
        end
    endtask

    task automatic test_24bit_stall();
        clr();
        push_word(0, 32'hDEADBEEF, 4'h7, 1'b1);
        push_word(1, 32'h5A123456, 4'h7, 1'b1);
        cyc = 0;
        ready_toggle = 1'b1;
        start_run(16'd2);
        wait_done(100, "24bit");
        ready_toggle = 1'b0;
        tx_ready = 1'b1;
        vectors++;
        if (popped != 6 || rdr_cnt != 1) begin
            misc++;
            $display("FAIL 24bit_counts: bytes=%0d rd_ready=%0d, required 6/1", popped, rdr_cnt);
        end
    endtask

    task automatic test_empty_keep();
        clr();
        push_word(0, 32'h11111111, 4'hF, 1'b0);
        push_word(1, 32'h00009900, 4'b0010, 1'b1);
        start_run(16'd2);
        wait_done(60, "empty");
        vectors++;
        if (popped != 1 || rdr_cnt != 1) begin
            misc++;
            $display("FAIL empty_counts: bytes=%0d rd_ready=%0d, required 1/1", popped, rdr_cnt);
        end
    endtask

    task automatic test_zero_count();
        clr();
        start_run(16'd0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            misc++;
            $display("FAIL zero_done_cycle1: done=%0b busy=%0b, required 1/0", done, busy);
        end
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (busy_seen || txv_seen || rdr_cnt != 0 || done_cnt != 1) begin
            misc++;
            $display("FAIL zero_activity: busy=%0b tx_valid=%0b rd_ready=%0d done=%0d, req 0/0/0/1",
                     busy_seen, txv_seen, rdr_cnt, done_cnt);
        end
    endtask

    task automatic test_abort();
        int c = 0;
        clr();
        push_word(0, 32'hDDCCBBAA, 4'hF, 1'b1);
        start_run(16'd1);
        while (popped < 2 && c < 40) begin
            tick();
            c++;
        end
        vectors++;
        if (popped < 2) begin
            misc++;
            $display("FAIL abort_reach_send: bytes=%0d, required 2", popped);
        end
        abort = 1'b1;
        tx_ready = 1'b0;
        tick();
        abort = 1'b0;
        tx_ready = 1'b1;
        vectors++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            misc++;
            $display("FAIL abort_idle: tx_valid=%0b busy=%0b, required 0/0", tx_valid, busy);
        end
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (done_cnt != 0 || popped != 2 || rdr_cnt != 0) begin
            misc++;
            $display("FAIL abort_after: done=%0d bytes=%0d rd_ready=%0d, required 0/2/0",
                     done_cnt, popped, rdr_cnt);
        end
        clr();
        push_word(0, 32'h00004321, 4'b0011, 1'b1);
        start_run(16'd1);
        wait_done(40, "post_abort");
        vectors++;
        if (popped != 2) begin
            misc++;
            $display("FAIL post_abort_bytes: got %0d, required 2", popped);
        end
    endtask

    task automatic test_reset_mid_and_start_ignored();
        int c = 0;
        clr();
        push_word(0, 32'h01020304, 4'hF, 1'b1);
        start_run(16'd1);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, rd_ready, tx_valid, tx_data} !== 12'h000) begin
            misc++;
            $display("FAIL reset_mid_wait: got %03h, required 000",
                     {busy, done, rd_ready, tx_valid, tx_data});
        end
        tick();
        rst = 1'b1;
        tick();
        clr();
        push_word(0, 32'hF3F2F1F0, 4'hF, 1'b1);
        push_word(1, 32'hE3E2E1E0, 4'hF, 1'b1);
        start_run(16'd2);
        while (popped < 1 && c < 40) begin
            tick();
            c++;
        end
        read_count = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(80, "restart");
        vectors++;
        if (popped != 8 || rdr_cnt != 1 || done_cnt != 1) begin
            misc++;
            $display("FAIL start_ignored: bytes=%0d rd_ready=%0d done=%0d, required 8/1/1",
                     popped, rdr_cnt, done_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem_data[i] = 32'd0;
            mem_keep[i] = 4'd0;
            mem_vld[i]  = 1'b0;
        end
        test_reset();
        test_full_words();
        test_8bit();
        test_24bit_stall();
        test_empty_keep();
        test_zero_count();
        test_abort();
        test_reset_mid_and_start_ignored();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule

// File: doc/sram_readout_ctrl.md
# sram_readout_ctrl

Sequences readback of captured samples from the 6K x 32 sample SRAM block and serializes them into a byte stream for the host transmitter. On `start`, it walks the SRAM read port backwards through `read_count` read steps using the `rd_ready` step strobe. For each step it captures the presented word and lane-keep mask, then emits each kept byte over a valid/ready byte interface. It sits between the SRAM wrapper's read interface and the UART/SPI transmit path, and is controlled by the core FSM.

## Interface
- `MDW`, 32: SRAM data width; fixed at four 8-bit lanes.
- `CW`, 16: width of the read-step counter.
- `RD_LAT`, 2: cycles from an SRAM address change (or from `start`) until `rd_data`/`rd_keep` are valid.

- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `start` in 1: one-cycle request to begin readback; ignored unless idle.
- `abort` in 1: synchronous cancel of a readback in progress.
- `read_count` in CW: number of SRAM read steps to perform; sampled when `start` is accepted.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle `done` pulses.
- `done` out 1: one-cycle pulse when all steps have been sent.
- `rd_ready` out 1: one-cycle strobe that steps the SRAM address down by one read step.
- `rd_valid` in 1: SRAM indicates at least one lane is valid.
- `rd_keep` in 4: per-lane valid mask; bit i covers `rd_data[8i+7:8i]`.
- `rd_data` in MDW: SRAM read word.
- `tx_valid` out 1: byte available on `tx_data`.
- `tx_data` out 8: byte to transmit.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid & tx_ready`.

## Operation
- State machine states: IDLE, WAIT, CAPT, SEND, STEP, DONE.
- IDLE
  - `start` with `read_count`≠0: load `cnt`=`read_count`, load `lat`=`RD_LAT`-1, go to WAIT.
  - `start` with `read_count`=0: go to DONE; no SRAM access.
- WAIT: decrement `lat` each cycle; at 0, go to CAPT. The first word needs no `rd_ready`, because the SRAM already presents the last-written word.
- CAPT (1 cycle)
  - Register `rd_data` into `hold` and `rd_keep & {4{rd_valid}}` into `pend`.
  - Decrement `cnt`.
  - If `pend`≠0, go to SEND.
  - Otherwise: go to STEP if `cnt`≠0, else DONE. The step is still counted.
- SEND
  - `tx_valid`=1; `tx_data` = `hold` lane of the lowest set bit of `pend`.
  - On `tx_ready`: clear that bit.
  - When the last bit clears: go to STEP if `cnt`≠0, else DONE.
- STEP (1 cycle): `rd_ready`=1, reload `lat`=`RD_LAT`-1, go to WAIT.
- DONE (1 cycle): `done`=1, go to IDLE.
- `abort` in any non-IDLE state: go to IDLE next cycle.
  - `tx_valid` drops.
  - No `done` pulse; no `rd_ready`.
  - A byte handshaked in the `abort` cycle counts as sent.
- `abort` and `start` together in IDLE: `start` is ignored.
- `start` while not IDLE: ignored; `cnt` is not reloaded.
- `tx_data` and `tx_valid` stay stable while `tx_valid & ~tx_ready` (no byte retraction except on `abort`/reset).
- `cnt` is unsigned CW-bit. A step count of 2^CW−1 is legal and does not wrap. SRAM address wrap is the SRAM block's concern.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_ready`=0, `tx_valid`=0, `tx_data`=0; state IDLE; `cnt`=0, `pend`=0.
- Reset mid-operation returns to IDLE asynchronously with all outputs at reset values.
- All outputs are registered or decoded from registered state only; there is no combinational path from `tx_ready` to `tx_valid`.
- `start` in cycle 0 → `busy`=1 in cycle 1 → CAPT in cycle `RD_LAT`+1 (cycle 3 at default) → first `tx_valid` in cycle `RD_LAT`+2.
- Per word with `tx_ready` held high: k kept bytes take k SEND cycles, plus STEP (1) + WAIT (`RD_LAT`) + CAPT (1).
- `rd_ready` is never high on two consecutive cycles; at most one `rd_ready` per CAPT.
- `rd_ready` count per run = `read_count`−1.
- `done` is high exactly one cycle after the final byte handshake (or CAPT with empty keep). `busy` falls in the same cycle as `done`.

## Test plan
- `read_count`=3, `rd_keep`=4'hF, `tx_ready`=1, words 0x44332211 / 0x88776655 / 0xCCBBAA99 → bytes 11,22,33,44,55,…,CC in order; exactly 2 `rd_ready` pulses; one `done`.
- 8-bit mode, `rd_keep` rotating 0001→1000→0100, `read_count`=3 → 3 bytes, one per step, taken from lanes 0, 3, 2.
- `rd_keep`=4'h7 (24-bit), `tx_ready` toggling 1-0-0-1 → 3 bytes per word; `tx_data` stable while stalled; lane 3 never sent.
- `read_count`=0 → `done` in cycle 1, `busy` never 1, no `rd_ready`, no `tx_valid`.
- `abort` during SEND after 2 of 4 bytes → IDLE next cycle, `tx_valid`=0, no `done`; a following `start` with `read_count`=1 completes normally.
- `rst` driven 0 mid-WAIT → all outputs 0 immediately; `start` applied mid-run → ignored, total bytes unchanged.
